// File: rtl/exon_bus_if.sv
// exon_bus_if: shared-bus control, data and status signals between a controller and the datapath
interface exon_bus_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic             enb;
    logic             enc;
    logic             eni;
    logic             lda;
    logic             ldb;
    logic             ldc;
    logic [WIDTH-1:0] inData;
    logic [WIDTH-1:0] rega;
    logic [WIDTH-1:0] regb;
    logic [WIDTH-1:0] regc;
    logic [WIDTH-1:0] zbus;
    logic             conflict;

    modport master (
        output ena, enb, enc, eni, lda, ldb, ldc, inData,
        input  rega, regb, regc, zbus, conflict
    );

    modport slave (
        input  ena, enb, enc, eni, lda, ldb, ldc, inData,
        output rega, regb, regc, zbus, conflict
    );
endinterface

// File: rtl/exon_bus.sv
// exon_bus: single shared bus with three general registers and an external input source
module exon_bus #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    exon_bus_if.slave  bus
);
    logic [WIDTH-1:0] rega_q, regb_q, regc_q;
    logic [WIDTH-1:0] rega_d, regb_d, regc_d;
    logic [WIDTH-1:0] zbus_w;

    // priority bus mux: inData beats A beats B beats C; idle bus reads zero
    always_comb begin
        zbus_w = bus.eni ? bus.inData :
                 bus.ena ? rega_q :
                 bus.enb ? regb_q :
                 bus.enc ? regc_q : '0;
    end

    // each selected register captures the pre-edge bus value
    always_comb begin
        rega_d = bus.lda ? zbus_w : rega_q;
        regb_d = bus.ldb ? zbus_w : regb_q;
        regc_d = bus.ldc ? zbus_w : regc_q;
    end

    // register bank; rst_n is active high and overrides every load
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rega_q <= '0;
            regb_q <= '0;
            regc_q <= '0;
        end else begin
            rega_q <= rega_d;
            regb_q <= regb_d;
            regc_q <= regc_d;
        end
    end

    assign bus.zbus     = zbus_w;
    assign bus.conflict = (32'(bus.eni) + 32'(bus.ena) + 32'(bus.enb) + 32'(bus.enc)) > 32'd1;
    assign bus.rega     = rega_q;
    assign bus.regb     = regb_q;
    assign bus.regc     = regc_q;
endmodule

// File: tb/tb_exon_bus.sv
// tb_exon_bus: randomized and directed checking of exon_bus against a behavioural model
module tb_exon_bus;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   run    = 1'b0;

    exon_bus_if #(.WIDTH(8)) b ();

    exon_bus #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] m_reg [3];

    function automatic logic [7:0] exp_bus();
        logic [7:0] src [4];
        logic       en  [4];
        src = '{b.inData, m_reg[0], m_reg[1], m_reg[2]};
        en  = '{b.eni, b.ena, b.enb, b.enc};
        for (int i = 0; i < 4; i++)
            if (en[i]) return src[i];
        return 8'h00;
    endfunction

    function automatic logic exp_conflict();
        return $countones({b.eni, b.ena, b.enb, b.enc}) > 1;
    endfunction

    always @(posedge clk) begin
        logic [7:0] v;
        logic       ld [3];
        v  = exp_bus();
        ld = '{b.lda, b.ldb, b.ldc};
        for (int i = 0; i < 3; i++)
            if (rst_n) m_reg[i] <= 8'h00;
            else if (ld[i]) m_reg[i] <= v;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("zbus", b.zbus, exp_bus());
            chk("conflict", {7'd0, b.conflict}, {7'd0, exp_conflict()});
            chk("rega", b.rega, m_reg[0]);
            chk("regb", b.regb, m_reg[1]);
            chk("regc", b.regc, m_reg[2]);
        end
    end

    task automatic set_en(input logic i, input logic a, input logic bb, input logic c);
        b.eni = i; b.ena = a; b.enb = bb; b.enc = c;
    endtask

    task automatic set_ld(input logic a, input logic bb, input logic c);
        b.lda = a; b.ldb = bb; b.ldc = c;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        set_en(1, 0, 0, 0);
        set_ld(1, 1, 1);
        b.inData = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        run = 1'b1;
        chk("rst_rega", b.rega, 8'h00);
        chk("rst_regb", b.regb, 8'h00);
        chk("rst_regc", b.regc, 8'h00);

        rst_n = 1'b0;
        set_ld(0, 0, 0);
        b.inData = 8'hAA;
        #1;
        chk("t2_zbus", b.zbus, 8'hAA);
        b.lda = 1'b1;
        edge_step();
        b.lda = 1'b0;
        chk("t2_rega", b.rega, 8'hAA);
        chk("t2_regb", b.regb, 8'h00);
        chk("t2_regc", b.regc, 8'h00);

        set_en(0, 1, 0, 0);
        #1;
        chk("t3_zbus", b.zbus, 8'hAA);
        set_ld(0, 1, 1);
        edge_step();
        set_ld(0, 0, 0);
        chk("t3_regb", b.regb, 8'hAA);
        chk("t3_regc", b.regc, 8'hAA);
        chk("t3_rega", b.rega, 8'hAA);

        set_en(1, 1, 0, 0);
        b.inData = 8'h55;
        #1;
        chk("t4_zbus", b.zbus, 8'h55);
        chk("t4_conflict", {7'd0, b.conflict}, 8'h01);
        b.lda = 1'b1;
        edge_step();
        b.lda = 1'b0;
        chk("t4_rega", b.rega, 8'h55);

        set_en(0, 0, 0, 0);
        b.ldc = 1'b1;
        #1;
        chk("t5_zbus", b.zbus, 8'h00);
        chk("t5_conflict", {7'd0, b.conflict}, 8'h00);
        edge_step();
        b.ldc = 1'b0;
        chk("t5_regc", b.regc, 8'h00);
        chk("t5_rega", b.rega, 8'h55);
        chk("t5_regb", b.regb, 8'hAA);

        set_en(1, 0, 0, 0);
        b.inData = 8'h3C;
        b.lda = 1'b1;
        edge_step();
        chk("t6_rega_pre", b.rega, 8'h3C);
        set_en(0, 1, 0, 0);
        set_ld(0, 1, 0);
        rst_n = 1'b1;
        edge_step();
        rst_n = 1'b0;
        set_en(0, 0, 0, 0);
        set_ld(0, 0, 0);
        chk("t6_rega", b.rega, 8'h00);
        chk("t6_regb", b.regb, 8'h00);
        chk("t6_regc", b.regc, 8'h00);

        for (int k = 0; k < 500; k++) begin
            logic [3:0] e;
            logic [2:0] l;
            e = 4'($urandom);
            l = 3'($urandom);
            rst_n = ($urandom_range(0, 29) == 0);
            set_en(e[3], e[2], e[1], e[0]);
            set_ld(l[2], l[1], l[0]);
            b.inData = 8'($urandom);
            edge_step();
        end

        @(negedge clk);
        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
